// File: rtl/rr_arb_mux_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_mux_pkg
// Shared constants and helpers for the round-robin arbitrated output mux.
//   DEF_N_CH  : default channel count
//   DEF_WIDTH : default data width per channel
//   sel_w()   : width of a channel index, max(1, $clog2(n))
//   IDX_ZERO  : reset value for channel indices (out_sel, ptr)
// -----------------------------------------------------------------------------
package rr_arb_mux_pkg;

   localparam int DEF_N_CH  = 4;
   localparam int DEF_WIDTH = 8;
   localparam int IDX_ZERO  = 0;

   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational arbiter. Picks the first requesting channel searching
// cyclically upward from ptr; with RR_ARB_MUX_FIXED_PRI_EN defined the ptr
// port is removed and the lowest-index requester always wins.
// Ports:
//   ptr   in  SEL_W  search start (round-robin build only)
//   req   in  N_CH   per-channel request
//   grant out N_CH   one-hot grant, all-zero when nothing requests
//   idx   out SEL_W  binary index of the granted channel (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter
   import rr_arb_mux_pkg::*;
#(
   parameter  int N_CH  = DEF_N_CH,
   localparam int SEL_W = sel_w(N_CH)
) (
`ifndef RR_ARB_MUX_FIXED_PRI_EN
   input  logic [SEL_W-1:0] ptr,
`endif
   input  logic [N_CH-1:0]  req,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] idx
);

   always_comb begin : search
      logic found;
      int   c;
      // NOTE: every output gets a default before the loop so no latch is inferred.
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < N_CH; k++) begin
`ifdef RR_ARB_MUX_FIXED_PRI_EN
         c = k;
`else
         // Offset from ptr, folded back into 0..N_CH-1.
         c = int'(ptr) + k;
         if (c >= N_CH) c = c - N_CH;
`endif
         if (!found && req[c]) begin
            found    = 1'b1;
            grant[c] = 1'b1;
            idx      = SEL_W'(c);
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// -----------------------------------------------------------------------------
// rr_arb_mux
// N-channel registered multiplexer with valid/ready handshakes on every side.
// An internal arbiter (rr_arbiter) chooses among requesting channels; the
// winning word is captured in a single output register.
// Build option: RR_ARB_MUX_FIXED_PRI_EN selects fixed lowest-index priority
// and removes the round-robin pointer.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   N_CH        per-channel request
//   in_data    in   N_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_ready   out  N_CH        per-channel accept, one-hot or zero
//   out_valid  out  1           output register holds a word
//   out_data   out  WIDTH       registered selected word
//   out_sel    out  SEL_W       source channel of out_data
//   out_ready  in   1           consumer accept
// -----------------------------------------------------------------------------
module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter  int N_CH  = DEF_N_CH,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int SEL_W = sel_w(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_sel,
   input  logic                  out_ready
);

   logic             load;
   logic             hs;
   logic [N_CH-1:0]  grant;
   logic [SEL_W-1:0] gidx;
   logic [WIDTH-1:0] word;

`ifndef RR_ARB_MUX_FIXED_PRI_EN
   logic [SEL_W-1:0] ptr;
`endif

   rr_arbiter #(.N_CH(N_CH)) u_arb (
`ifndef RR_ARB_MUX_FIXED_PRI_EN
      .ptr   (ptr),
`endif
      .req   (in_valid),
      .grant (grant),
      .idx   (gidx)
   );

   // Output register is free when empty or being drained this cycle.
   assign load     = ~out_valid | out_ready;
   assign in_ready = rst ? '0 : (grant & {N_CH{load}});
   assign hs       = |in_ready;

   // One-hot AND-OR select keeps every part-select index constant.
   always_comb begin
      word = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) word = word | in_data[i*WIDTH +: WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= SEL_W'(IDX_ZERO);
      end else if (load) begin
         if (hs) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_sel   <= gidx;
         end else begin
            // Drained with nothing to replace it; data and sel hold.
            out_valid <= 1'b0;
         end
      end
   end

`ifndef RR_ARB_MUX_FIXED_PRI_EN
   // Pointer moves to the channel after the winner, only on a handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= SEL_W'(IDX_ZERO);
      end else if (hs) begin
         ptr <= (gidx == SEL_W'(N_CH-1)) ? SEL_W'(IDX_ZERO) : gidx + SEL_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_rr_arb_mux
// Self-checking bench for rr_arb_mux (N_CH=4, WIDTH=8). A behavioural model
// tracks the output register and the next-search position; a compare process
// checks every DUT output on each falling edge. Directed phases pin known
// sequences with literal values, then a randomized phase runs against the
// model. Honours RR_ARB_MUX_FIXED_PRI_EN.
// -----------------------------------------------------------------------------
module tb_rr_arb_mux;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [0:0]     out_sel_raw;
   logic [1:0]     out_sel;
   logic           out_ready;

   int checks = 0;
   int errors = 0;

   rr_arb_mux #(.N_CH(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   assign out_sel_raw = 1'b0;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           armed = 1'b0;
   bit           m_valid = 1'b0;
   logic [W-1:0] m_data = '0;
   int           m_sel = 0;
   int           m_ptr = 0;
   bit           n_valid;
   logic [W-1:0] n_data;
   int           n_sel;
   int           n_ptr;

   always @(negedge clk) begin
      if (armed) begin
         int           start;
         int           winner;
         bit           can_take;
         logic [N-1:0] exp_ready;
`ifdef RR_ARB_MUX_FIXED_PRI_EN
         start = 0;
`else
         start = m_ptr;
`endif
         winner = -1;
         for (int d = 0; d < N; d++) begin
            if (winner < 0 && in_valid[(start + d) % N]) winner = (start + d) % N;
         end
         can_take  = !m_valid || out_ready;
         exp_ready = '0;
         if (!rst && can_take && winner >= 0) exp_ready[winner] = 1'b1;

         check("in_ready",  32'(in_ready),  32'(exp_ready));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("out_data",  32'(out_data),  32'(m_data));
         check("out_sel",   32'(out_sel),   32'(m_sel));

         n_valid = m_valid; n_data = m_data; n_sel = m_sel; n_ptr = m_ptr;
         if (rst) begin
            n_valid = 1'b0; n_data = '0; n_sel = 0; n_ptr = 0;
         end else if (can_take) begin
            if (winner >= 0) begin
               n_valid = 1'b1;
               n_data  = in_data[winner*W +: W];
               n_sel   = winner;
               n_ptr   = (winner + 1) % N;
            end else begin
               n_valid = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (armed) begin
         m_valid <= n_valid; m_data <= n_data; m_sel <= n_sel; m_ptr <= n_ptr;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fixed_data();
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      set_fixed_data();

      // Reset held two cycles with all channels valid.
      cyc();
      armed = 1'b1;
      cyc();
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'h0);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_data",  32'(out_data),  32'h0);
      check("rst_out_sel",   32'(out_sel),   32'h0);
      cyc();
      rst = 1'b0;

`ifndef RR_ARB_MUX_FIXED_PRI_EN
      // Round-robin sweep, one word per cycle.
      for (int k = 0; k < 8; k++) begin
         cyc();
         @(negedge clk);
         check("sweep_sel",  32'(out_sel),  32'(k % 4));
         check("sweep_data", 32'(out_data), 32'(8'hA0 + 8'(k % 4)));
      end
      cyc();
      cyc();
      // Backpressure with A1 held.
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_data",     32'(out_data), 32'hA1);
         check("bp_in_ready", 32'(in_ready), 32'h0);
         cyc();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_hold_data", 32'(out_data), 32'hA1);
      cyc();
      in_valid = 4'b1010;
      @(negedge clk);
      check("bp_release_sel", 32'(out_sel), 32'd2);
      // Sparse requests with wrap from ptr=3.
      cyc();
      @(negedge clk);
      check("sparse_sel0", 32'(out_sel), 32'd3);
      cyc();
      @(negedge clk);
      check("sparse_sel1", 32'(out_sel), 32'd1);
      cyc();
      in_valid = 4'b0100;
      @(negedge clk);
      check("sparse_sel2", 32'(out_sel), 32'd3);
      // Idle drain of a single word on ch2.
      cyc();
      in_valid = 4'b0000;
      @(negedge clk);
      check("drain_sel",   32'(out_sel),   32'd2);
      check("drain_valid", 32'(out_valid), 32'd1);
      cyc();
      in_valid = 4'b1111;
      @(negedge clk);
      check("drain_empty",     32'(out_valid), 32'd0);
      check("drain_hold_data", 32'(out_data),  32'hA2);
      cyc();
      @(negedge clk);
      check("ptr3_sel", 32'(out_sel), 32'd3);
      // Mid-stream reset.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(out_valid), 32'd0);
      cyc();
      @(negedge clk);
      check("midrst_ptr0_sel", 32'(out_sel), 32'd0);
`else
      // Fixed priority: channel 0 wins every cycle.
      for (int k = 0; k < 8; k++) begin
         cyc();
         @(negedge clk);
         check("fixed_sel",  32'(out_sel),  32'd0);
         check("fixed_data", 32'(out_data), 32'hA0);
      end
`endif

      // Randomized phase against the model.
      for (int k = 0; k < 600; k++) begin
         cyc();
         in_valid  = 4'($urandom_range(0, 15));
         in_data   = 32'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         rst       = ($urandom_range(0, 99) == 0);
      end
      cyc();
      rst = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel registered multiplexer with valid/ready handshakes and round-robin arbitration, the next generation of the team's 4:1 select mux. It replaces externally driven select lines with an internal arbiter that chooses among requesting input channels. The selected word is presented on a single registered output port. It sits between multiple producer blocks and one shared downstream consumer.

## Interface
- N_CH, 4: number of input channels, minimum 2.
- WIDTH, 8: data width per channel.
- clk  input  1  single clock; all logic samples on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N_CH  per-channel request.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N_CH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  $clog2(N_CH)  index of the channel that out_data came from.
- out_ready  input  1  consumer accept.

## Operation
- Reset state: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
- in_ready is 0 on every channel while rst is high.
- load = ~out_valid | out_ready. The output register can accept a new word in any cycle where it is empty or is being drained in the same cycle.
- grant: the first channel i with in_valid[i]=1, searching cyclically from ptr (ptr, ptr+1, …, N_CH-1, 0, …). grant is all-zero when no channel is valid.
- in_ready = grant & {N_CH{load}}. This is combinational from in_valid, ptr, out_valid and out_ready.
- Input handshake on channel g (in_valid[g] & in_ready[g]), at the next edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - ptr <= (g==N_CH-1) ? 0 : g+1
- If load=1 and no channel is valid: out_valid <= 0. out_data and out_sel hold their values.
- If out_valid=1 and out_ready=0: out_valid, out_data and out_sel all hold. in_ready=0 on every channel.
- ptr changes only on an input handshake.
- A producer must hold in_data stable while in_valid=1 and it is not yet accepted. The block does not check this rule.

## Timing
- Latency: 1 cycle from input handshake to out_valid=1.
- Throughput: 1 word per cycle with out_ready held high. Simultaneous drain and load in the same cycle is required behaviour.
- Fairness: with all N_CH channels requesting continuously, each channel is granted exactly once in every N_CH consecutive handshakes.
- Single requester: a lone valid channel is granted every load cycle, regardless of ptr.
- Wrap-around: a grant of channel N_CH-1 sets ptr to 0.
- Reset asserted mid-transfer: at the next edge out_valid=0 and ptr=0. The held word is discarded without a handshake.
- in_ready never goes high for a channel whose in_valid is 0.

## Configuration
- RR_ARB_MUX_FIXED_PRI_EN
  - Defined: fixed priority, where the lowest-index valid channel always wins. ptr and its register are removed, and out_sel behaves as before. Channel starvation is allowed in this mode.
  - Undefined (default): round-robin arbitration as described under Operation.

## Structure
- Package rr_arb_mux_pkg holds:
  - default constants for N_CH and WIDTH
  - a sel-width helper returning max(1, $clog2(N_CH))
  - the constant IDX_ZERO used for reset of out_sel and ptr
- Sub-module rr_arbiter: purely combinational.
  - Inputs: req (N_CH), ptr.
  - Output: one-hot grant plus its binary index.
  - Honours RR_ARB_MUX_FIXED_PRI_EN.
- The top level holds ptr, the output register and the handshake logic.

## Test plan
- Reset check: hold rst for 2 cycles with all channels valid. Required: in_ready=0000, out_valid=0, out_data=0, out_sel=0.
- Round-robin sweep: N_CH=4, WIDTH=8, in_data channel i = 8'hA0+i, all valid, out_ready=1. Required: out_sel sequence 0,1,2,3,0,… and out_data A0,A1,A2,A3,A0, one word per cycle.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=A1. Required: out_data stays A1, in_ready=0000 throughout. On release, next out_sel=2.
- Sparse requests with wrap: ptr=3, only ch1 and ch3 valid. Required: ch3 granted first, then ch1, then ch3.
- Idle drain: a single word on ch2, then all channels invalid with out_ready=1. Required: out_valid drops 1 cycle after the word is consumed, and ptr=3.
- Mid-stream reset, then FIXED_PRI build:
  - Assert rst while out_valid=1. Required: out_valid=0 and ptr=0 next cycle.
  - Rebuild with the macro defined, all channels valid. Required: out_sel stays 0 every cycle.
